// File: rtl/bike_pkg.sv
// Shared constants and helpers for the bike motion engine.
package bike_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int unsigned SCR_W  = 640;
  localparam int unsigned SCR_H  = 480;
  localparam int unsigned SPR    = 30;
  localparam int unsigned X_MAX  = SCR_W - SPR;
  localparam int unsigned Y_MAX  = SCR_H - SPR;

  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned TICK_W = 20;
  localparam int unsigned ADDR_W = 32;

  // Heading that points back the way the bike came.
  function automatic logic [1:0] opposite(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

  // Linear sprite address y*640+x built from shifts.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step divider: strobes tick_out on the last enabled cycle of each DIV period.
module step_timer
  import bike_pkg::*;
#(
  parameter logic [TICK_W-1:0] DIV = 20'd4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick_out
);

  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_d;
  logic              at_end;

  // Advance or wrap the divider while running; hold otherwise.
  always_comb begin
    tick_d   = tick_q;
    at_end   = (tick_q == (DIV - TICK_W'(1)));
    tick_out = run && at_end;
    if (run) begin
      tick_d = at_end ? '0 : (tick_q + TICK_W'(1));
    end
  end

  // Divider register; restart clears it like reset.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/bike_motion_ctrl.sv
// Per-player motion engine: owns one bike's position, heading and crash state.
module bike_motion_ctrl
  import bike_pkg::*;
#(
  parameter logic [X_W-1:0]    START_X   = 10'd100,
  parameter logic [Y_W-1:0]    START_Y   = 9'd200,
  parameter logic [1:0]        START_DIR = 2'd1,
  parameter logic [TICK_W-1:0] STEP_DIV  = 20'd4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic              dir_req_valid,
  input  logic [1:0]        dir_req,
  input  logic              crash_in,
  output logic [ADDR_W-1:0] bike_addr,
  output logic [31:0]       bike_orient,
  output logic [X_W-1:0]    bike_x,
  output logic [Y_W-1:0]    bike_y,
  output logic              crashed,
  output logic              step_pulse
);

  typedef enum logic {ST_RUN, ST_FROZEN} state_t;

  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d, nx;
  logic [Y_W-1:0] y_q, y_d, ny;
  logic [1:0]     dir_q, dir_d;
  logic [1:0]     pend_q, pend_d;
  logic           pulse_q, pulse_d;
  logic           blocked;
  logic           step;

  step_timer #(.DIV(STEP_DIV)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (restart),
    .run      (enable && (state_q == ST_RUN)),
    .tick_out (step)
  );

  // Next state: direction latching, crash freeze, bounded one-pixel step.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    pulse_d = 1'b0;
    nx      = x_q;
    ny      = y_q;
    blocked = 1'b0;

    unique case (pend_q)
      DIR_UP: begin
        blocked = (y_q == '0);
        if (!blocked) ny = y_q - Y_W'(1);
      end
      DIR_RIGHT: begin
        blocked = (x_q >= X_LIM);
        if (!blocked) nx = x_q + X_W'(1);
      end
      DIR_DOWN: begin
        blocked = (y_q >= Y_LIM);
        if (!blocked) ny = y_q + Y_W'(1);
      end
      default: begin
        blocked = (x_q == '0);
        if (!blocked) nx = x_q - X_W'(1);
      end
    endcase

    if (state_q == ST_RUN) begin
      if (dir_req_valid && (dir_req != opposite(dir_q))) begin
        pend_d = dir_req;
      end
      if (crash_in) begin
        state_d = ST_FROZEN;
      end else if (step) begin
        dir_d = pend_q;
        if (blocked) begin
          state_d = ST_FROZEN;
        end else begin
          x_d     = nx;
          y_d     = ny;
          pulse_d = 1'b1;
        end
      end
    end
  end

  // State registers; restart reloads the start pose exactly like reset.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      state_q <= ST_RUN;
      x_q     <= START_X;
      y_q     <= START_Y;
      dir_q   <= START_DIR;
      pend_q  <= START_DIR;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
    end
  end

  assign bike_x      = x_q;
  assign bike_y      = y_q;
  assign bike_addr   = lin_addr(x_q, y_q);
  assign bike_orient = {30'b0, dir_q};
  assign crashed     = (state_q == ST_FROZEN);
  assign step_pulse  = pulse_q;

endmodule

// File: tb/tb_bike_motion_ctrl.sv
// Bench for bike_motion_ctrl: directed vector table, wall corner case, random vs model.
module tb_bike_motion_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_rst, a_en, a_rs, a_v, a_cr;
  logic [1:0]  a_dr;
  logic [31:0] a_addr, a_or;
  logic [9:0]  a_x;
  logic [8:0]  a_y;
  logic        a_crashed, a_pulse;

  logic        b_rst, b_en, b_rs, b_v, b_cr;
  logic [1:0]  b_dr;
  logic [31:0] b_addr, b_or;
  logic [9:0]  b_x;
  logic [8:0]  b_y;
  logic        b_crashed, b_pulse;

  bike_motion_ctrl dut_a (
    .clock(clock), .reset(a_rst), .enable(a_en), .restart(a_rs),
    .dir_req_valid(a_v), .dir_req(a_dr), .crash_in(a_cr),
    .bike_addr(a_addr), .bike_orient(a_or), .bike_x(a_x), .bike_y(a_y),
    .crashed(a_crashed), .step_pulse(a_pulse)
  );

  bike_motion_ctrl #(.START_X(10'd609), .STEP_DIV(20'd1)) dut_b (
    .clock(clock), .reset(b_rst), .enable(b_en), .restart(b_rs),
    .dir_req_valid(b_v), .dir_req(b_dr), .crash_in(b_cr),
    .bike_addr(b_addr), .bike_orient(b_or), .bike_x(b_x), .bike_y(b_y),
    .crashed(b_crashed), .step_pulse(b_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: plain integer position, heading and divider count.
  typedef struct {
    int x; int y; int dir; int pend; int tick;
    bit frozen; bit pulse;
  } mdl_t;

  function automatic mdl_t mdl_start(input int sx, input int sy, input int sd);
    mdl_t m;
    m.x = sx; m.y = sy; m.dir = sd; m.pend = sd; m.tick = 0;
    m.frozen = 1'b0; m.pulse = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input bit rst, input bit en, input bit rs,
                                    input bit v, input int dr, input bit cr,
                                    input int div, input int sx, input int sy, input int sd);
    mdl_t n;
    int dxs [4];
    int dys [4];
    int nx, ny;
    dxs = '{0, 1, 0, -1};
    dys = '{-1, 0, 1, 0};
    n = m;
    n.pulse = 1'b0;
    if (rst || rs) return mdl_start(sx, sy, sd);
    if (m.frozen) return n;
    if (v && (dr != ((m.dir + 2) % 4))) n.pend = dr;
    if (en) n.tick = (m.tick + 1) % div;
    if (cr) begin
      n.frozen = 1'b1;
    end else if (en && (m.tick == div - 1)) begin
      nx = m.x + dxs[m.pend];
      ny = m.y + dys[m.pend];
      n.dir = m.pend;
      if (nx < 0 || nx > 610 || ny < 0 || ny > 450) begin
        n.frozen = 1'b1;
      end else begin
        n.x = nx; n.y = ny; n.pulse = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk_out(input string tag, input int ex, input int ey, input int ed,
                         input bit ec, input bit ep,
                         input logic [9:0] x, input logic [8:0] y, input logic [31:0] orient,
                         input logic [31:0] addr, input logic c, input logic p);
    chk({tag, ".x"},       32'(x),      32'(ex));
    chk({tag, ".y"},       32'(y),      32'(ey));
    chk({tag, ".orient"},  orient,      32'(ed));
    chk({tag, ".addr"},    addr,        32'(ey * 640 + ex));
    chk({tag, ".crashed"}, 32'(c),      32'(ec));
    chk({tag, ".pulse"},   32'(p),      32'(ep));
  endtask

  typedef struct {
    bit rst; bit en; bit rs; bit v; logic [1:0] dr; bit cr;
    int ex; int ey; int ed; bit ec; bit ep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit en, input bit rs, input bit v, input logic [1:0] dr,
                     input bit cr, input int ex, input int ey, input int ed, input bit ec, input bit ep);
    vec_t t;
    t.rst = rst; t.en = en; t.rs = rs; t.v = v; t.dr = dr; t.cr = cr;
    t.ex = ex; t.ey = ey; t.ed = ed; t.ec = ec; t.ep = ep;
    vecs.push_back(t);
  endtask

  mdl_t ma, mb;

  initial begin
    {a_rst, a_en, a_rs, a_v, a_cr} = '0; a_dr = 2'd0;
    {b_rst, b_en, b_rs, b_v, b_cr} = '0; b_dr = 2'd0;

    // Directed table on the default instance (start 100,200 right, divide by 4).
    add(1,0,0,0,0,0, 100,200,1,0,0);
    for (int i = 0; i < 3; i++) add(0,1,0,0,0,0, 100,200,1,0,0);
    add(0,1,0,0,0,0, 101,200,1,0,1);
    add(0,1,0,1,0,0, 101,200,1,0,0);
    add(0,1,0,0,0,0, 101,200,1,0,0);
    add(0,1,0,0,0,0, 101,200,1,0,0);
    add(0,1,0,0,0,0, 101,199,0,0,1);
    add(0,1,0,1,2,0, 101,199,0,0,0);
    add(0,1,0,0,0,0, 101,199,0,0,0);
    add(0,1,0,0,0,0, 101,199,0,0,0);
    add(0,1,0,0,0,0, 101,198,0,0,1);
    add(0,0,0,1,3,0, 101,198,0,0,0);
    for (int i = 0; i < 9; i++) add(0,0,0,0,0,0, 101,198,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,0,0,0,0, 101,198,0,0,0);
    add(0,1,0,0,0,0, 100,198,3,0,1);
    add(0,1,0,0,0,1, 100,198,3,1,0);
    add(0,1,0,1,0,0, 100,198,3,1,0);
    for (int i = 0; i < 3; i++) add(0,1,0,0,0,0, 100,198,3,1,0);
    add(0,1,1,0,0,0, 100,200,1,0,0);
    for (int i = 0; i < 3; i++) add(0,1,0,0,0,0, 100,200,1,0,0);
    add(0,1,0,0,0,0, 101,200,1,0,1);
    for (int i = 0; i < 3; i++) add(0,1,0,0,0,0, 101,200,1,0,0);
    add(0,1,0,0,0,1, 101,200,1,1,0);
    add(0,1,0,1,0,0, 101,200,1,1,0);
    add(1,1,0,0,0,0, 100,200,1,0,0);
    for (int i = 0; i < 3; i++) add(0,1,0,0,0,0, 100,200,1,0,0);
    add(0,1,0,0,0,0, 101,200,1,0,1);

    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      a_rst = vecs[i].rst; a_en = vecs[i].en; a_rs = vecs[i].rs;
      a_v = vecs[i].v; a_dr = vecs[i].dr; a_cr = vecs[i].cr;
      @(posedge clock); #1;
      chk_out($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ed, vecs[i].ec, vecs[i].ep,
              a_x, a_y, a_or, a_addr, a_crashed, a_pulse);
      @(negedge clock);
    end

    // Right wall: 609 -> 610, then the blocked step freezes without moving.
    b_rst = 1'b1;
    @(posedge clock); #1;
    chk_out("wall.rst", 609, 200, 1, 0, 0, b_x, b_y, b_or, b_addr, b_crashed, b_pulse);
    @(negedge clock); b_rst = 1'b0; b_en = 1'b1;
    @(posedge clock); #1;
    chk_out("wall.step1", 610, 200, 1, 0, 1, b_x, b_y, b_or, b_addr, b_crashed, b_pulse);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); b_v = (i == 1); b_dr = 2'd2;
      @(posedge clock); #1;
      chk_out($sformatf("wall.hold%0d", i), 610, 200, 1, 1, 0, b_x, b_y, b_or, b_addr, b_crashed, b_pulse);
    end
    @(negedge clock); b_v = 1'b0; b_rs = 1'b1;
    @(posedge clock); #1;
    chk_out("wall.restart", 609, 200, 1, 0, 0, b_x, b_y, b_or, b_addr, b_crashed, b_pulse);

    // Random phase: both instances against the model.
    @(negedge clock);
    a_rst = 1'b1; b_rst = 1'b1; b_rs = 1'b0;
    a_en = 1'b0; b_en = 1'b0; a_v = 1'b0; b_v = 1'b0; a_cr = 1'b0; b_cr = 1'b0; a_rs = 1'b0;
    @(posedge clock); #1;
    ma = mdl_start(100, 200, 1);
    mb = mdl_start(609, 200, 1);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      a_rst = ($urandom_range(0, 299) == 0);
      a_rs  = ($urandom_range(0, 79) == 0);
      a_en  = ($urandom_range(0, 9) < 8);
      a_v   = ($urandom_range(0, 3) == 0);
      a_dr  = 2'($urandom_range(0, 3));
      a_cr  = ($urandom_range(0, 399) == 0);
      b_rst = ($urandom_range(0, 299) == 0);
      b_rs  = ($urandom_range(0, 29) == 0);
      b_en  = ($urandom_range(0, 9) < 8);
      b_v   = ($urandom_range(0, 3) == 0);
      b_dr  = 2'($urandom_range(0, 3));
      b_cr  = ($urandom_range(0, 399) == 0);
      ma = mdl_next(ma, a_rst, a_en, a_rs, a_v, int'(a_dr), a_cr, 4, 100, 200, 1);
      mb = mdl_next(mb, b_rst, b_en, b_rs, b_v, int'(b_dr), b_cr, 1, 609, 200, 1);
      @(posedge clock); #1;
      chk_out($sformatf("rndA%0d", i), ma.x, ma.y, ma.dir, ma.frozen, ma.pulse,
              a_x, a_y, a_or, a_addr, a_crashed, a_pulse);
      chk_out($sformatf("rndB%0d", i), mb.x, mb.y, mb.dir, mb.frozen, mb.pulse,
              b_x, b_y, b_or, b_addr, b_crashed, b_pulse);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
